fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the team's synchronous FIFO among NUM_REQ independent producers.
- Round-robin arbitration with burst hold: a granted producer may push up to MAX_BURST words before the grant rotates.
- Sits between producer valid/ready interfaces and the FIFO wr_en/wr_data/full/almost_full pins.
- Write outputs are registered; the block accounts for the one in-flight write so the FIFO never sees wr_en while full (FIFO overflow never pulses).

---
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write-port arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int IDX_BITS   = $clog2(NUM_REQ),
  parameter int CNT_BITS   = $clog2(MAX_BURST) + 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almost_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          grant_valid;
  logic [IDX_BITS-1:0]           grant_idx;
  logic [CNT_BITS-1:0]           burst_cnt;

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_almost_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_idx, burst_cnt
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_almost_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_idx, burst_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst hold sharing one synchronous-FIFO write port
// among NUM_REQ producers; FIFO write outputs are registered.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int IDX_BITS   = $clog2(NUM_REQ)
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int CNT_BITS = $clog2(MAX_BURST) + 1;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t                r_state;
  logic [IDX_BITS-1:0]   r_rr_ptr;
  logic [IDX_BITS-1:0]   r_grant_idx;
  logic [CNT_BITS-1:0]   r_burst_cnt;
  logic                  r_grant_valid;
  logic                  r_wr_en_p1;
  logic [DATA_WIDTH-1:0] r_wr_data_p1;

  logic                  w_space_ok;
  logic                  w_any_valid;
  logic                  w_cur_valid;
  logic                  w_accept;
  logic                  w_burst_done;
  logic [IDX_BITS-1:0]   w_winner;
  logic [DATA_WIDTH-1:0] w_cur_data;
  logic [NUM_REQ-1:0]    w_ready;

  function automatic logic [IDX_BITS-1:0] wrap_inc(input logic [IDX_BITS-1:0] idx);
    return (idx == IDX_BITS'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Searching from the far end backwards leaves the nearest set bit after rr_ptr as winner.
  always_comb begin
    int k;
    w_winner    = r_rr_ptr;
    w_any_valid = |bus.req_valid;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (bus.req_valid[k]) w_winner = IDX_BITS'(k);
    end
  end

  // A registered write not yet reflected in almost_full would take the last slot.
  assign w_space_ok   = !bus.fifo_full && !(bus.fifo_almost_full && r_wr_en_p1);
  assign w_cur_valid  = bus.req_valid[r_grant_idx];
  assign w_cur_data   = bus.req_data[int'(r_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_accept     = (r_state == ST_GRANT) && w_cur_valid && w_space_ok;
  assign w_burst_done = (r_burst_cnt == CNT_BITS'(MAX_BURST - 1));

  always_comb begin
    w_ready = '0;
    if (r_state == ST_GRANT) w_ready[r_grant_idx] = w_space_ok;
  end

  // Stage p0 -> p1: accepted word becomes the FIFO write on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant_idx   <= '0;
      r_burst_cnt   <= '0;
      r_grant_valid <= 1'b0;
      r_wr_en_p1    <= 1'b0;
      r_wr_data_p1  <= '0;
    end else begin
      r_wr_en_p1 <= w_accept;
      if (w_accept) begin
        r_wr_data_p1 <= w_cur_data;
        r_burst_cnt  <= r_burst_cnt + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_state       <= ST_GRANT;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_winner;
            r_burst_cnt   <= '0;
          end
        end
        ST_GRANT: begin
          if ((w_accept && w_burst_done) || !w_cur_valid) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= wrap_inc(r_grant_idx);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.fifo_wr_en   = r_wr_en_p1;
  assign bus.fifo_wr_data = r_wr_data_p1;
  assign bus.grant_valid  = r_grant_valid;
  assign bus.grant_idx    = r_grant_idx;
  assign bus.burst_cnt    = r_burst_cnt;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(r_wr_en_p1 && bus.fifo_full));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: producers and a FIFO occupancy model
// drive the DUT; a reference model feeds a scoreboard checked by a write monitor.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  int            rem[N];
  logic [DW-1:0] cur[N];
  bit            seq_data;
  int            cnt;

  // Reference model: who owns the port, words taken, who has priority next.
  bit            model_ok;
  bit            m_grant;
  int            m_idx, m_cnt, m_ptr;
  bit            m_wr_en;
  logic [DW-1:0] m_wr_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected actual=%0h required=none at %0t", bus.fifo_wr_data, $time);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        if (bus.fifo_wr_data !== e) begin
          errors++;
          $display("FAIL wr_data actual=%0h required=%0h at %0t", bus.fifo_wr_data, e, $time);
        end
      end
    end
  end

  // One clock cycle: entered and left on a negedge.
  task automatic step(input bit do_rst, input int vprob, input int rprob);
    logic [N-1:0]    v, exp_rdy;
    logic [N*DW-1:0] d;
    bit              space, acc, rd, wr_s, found;
    int              acc_idx;

    for (int i = 0; i < N; i++) begin
      v[i] = !do_rst && (rem[i] > 0) && ($urandom_range(99) < vprob);
      d[i*DW +: DW] = cur[i];
    end
    rst                  = do_rst;
    bus.req_valid        = v;
    bus.req_data         = d;
    bus.fifo_full        = (cnt >= DEPTH);
    bus.fifo_almost_full = (cnt >= DEPTH - 1);
    #1;

    space   = (cnt + (m_wr_en ? 1 : 0)) < DEPTH;
    exp_rdy = '0;
    if (m_grant) exp_rdy[m_idx] = space;
    wr_s = (bus.fifo_wr_en === 1'b1);

    if (model_ok) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("grant_valid", 32'(bus.grant_valid), 32'(m_grant));
      chk("grant_idx", 32'(bus.grant_idx), m_idx);
      chk("burst_cnt", 32'(bus.burst_cnt), m_cnt);
      chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(m_wr_en));
      chk("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(m_wr_data));
      chk("overflow", 32'(wr_s && (cnt >= DEPTH)), 0);
    end

    acc     = m_grant && v[m_idx] && space;
    acc_idx = m_idx;
    if (acc) sb.push_back(cur[acc_idx]);
    rd = (cnt > 0) && ($urandom_range(99) < rprob);

    @(posedge clk);
    cnt = cnt + (wr_s ? 1 : 0) - (rd ? 1 : 0);

    if (do_rst) begin
      m_grant = 0; m_idx = 0; m_cnt = 0; m_ptr = 0;
      m_wr_en = 0; m_wr_data = '0; model_ok = 1;
    end else if (!m_grant) begin
      m_wr_en = 0;
      found   = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && v[(m_ptr + k) % N]) begin
          found = 1;
          m_idx = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_grant = 1;
        m_cnt   = 0;
      end
    end else begin
      m_wr_en = acc;
      if (acc) begin
        m_wr_data = cur[acc_idx];
        m_cnt++;
      end
      if ((acc && m_cnt == MB) || !v[m_idx]) begin
        m_grant = 0;
        m_ptr   = (m_idx + 1) % N;
      end
    end

    if (acc) begin
      rem[acc_idx]--;
      cur[acc_idx] = seq_data ? cur[acc_idx] + 8'd1 : 8'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic clear_rem();
    for (int i = 0; i < N; i++) rem[i] = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;
    bus.fifo_almost_full = 1'b0;
    cnt = 0;
    seq_data = 0;
    model_ok = 0;
    m_grant = 0; m_idx = 0; m_cnt = 0; m_ptr = 0; m_wr_en = 0; m_wr_data = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      cur[i] = '0;
    end
    @(negedge clk);

    step(1, 0, 0);
    step(1, 0, 0);
    repeat (2) step(0, 0, 0);

    // Single producer 1: 0x10..0x13, bubble, regrant, 0x14..0x15.
    seq_data = 1;
    cur[1] = 8'h10;
    rem[1] = 6;
    repeat (16) step(0, 100, 0);
    chk("single_writes", cnt, 6);
    repeat (10) step(0, 0, 100);
    seq_data = 0;

    // Full contention, one read per cycle so no stalls.
    for (int i = 0; i < N; i++) begin
      rem[i] = 1000;
      cur[i] = 8'($urandom);
    end
    repeat (44) step(0, 100, 100);
    clear_rem();
    repeat (12) step(0, 0, 100);

    // Grant to 3, then 0 and 3 both valid: 0 must win.
    rem[3] = 1;
    repeat (4) step(0, 100, 100);
    rem[0] = 3;
    rem[3] = 3;
    repeat (14) step(0, 100, 100);

    // Early release after two words from producer 0.
    clear_rem();
    rem[0] = 2;
    repeat (6) step(0, 100, 100);
    repeat (20) step(0, 0, 100);

    // Full boundary: FIFO at 14, producer 2 streaming.
    clear_rem();
    cnt = 14;
    rem[2] = 20;
    repeat (8) step(0, 100, 0);
    chk("full_fill", cnt, 16);
    step(0, 100, 100);
    repeat (4) step(0, 100, 0);
    chk("full_refill", cnt, 16);
    clear_rem();
    repeat (24) step(0, 0, 100);

    // Reset during beat 3 of a grant to producer 1, then all contend.
    rem[1] = 20;
    repeat (3) step(0, 100, 100);
    step(1, 0, 100);
    for (int i = 0; i < N; i++) rem[i] = 8;
    repeat (10) step(0, 100, 100);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) rem[$urandom_range(N-1)] = $urandom_range(1, 8);
      if ($urandom_range(499) == 0) step(1, 0, 50);
      else step(0, $urandom_range(40, 100), 45);
    end

    clear_rem();
    repeat (30) step(0, 0, 100);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
